// File: rtl/dport_cache_pkg.sv
// Shared types and helpers for the MEM-stage data cache.
// Contents: line/offset/word types, the cache FSM state enum,
// and word read / byte-merge helpers on a 128-bit line.
package dport_cache_pkg;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned WORD_W = 16;

    typedef logic [LINE_W-1:0] lc3b_line;
    typedef logic [2:0]        lc3b_c_offset;
    typedef logic [WORD_W-1:0] lc3b_word;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } dport_cache_state_t;

    // Word k of a line lives in bits [16k+15:16k].
    function automatic lc3b_word line_word(input lc3b_line line, input lc3b_c_offset off);
        return line[{off, 4'b0000} +: WORD_W];
    endfunction

    // Merge a lane-aligned write word into one word of a line under a byte mask.
    function automatic lc3b_line merge_word(input lc3b_line line, input lc3b_c_offset off,
                                            input lc3b_word wdata, input logic [1:0] be);
        lc3b_line r;
        r = line;
        if (be[0]) r[{off, 4'b0000} +: 8] = wdata[7:0];
        if (be[1]) r[{off, 4'b1000} +: 8] = wdata[15:8];
        return r;
    endfunction

endpackage

// File: rtl/dport_cache_array.sv
// NUM_SETS-entry storage array (data, tag, valid and dirty arrays of the cache).
// Ports: clk, rst (async active-high, clears every entry to 0), load (write
// enable), index (entry select), din (write data), dout (combinational read).
module dport_cache_array #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned IW       = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [IW-1:0]    index,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [NUM_SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SETS; i++) mem[IW'(i)] <= '0;
        end else if (load) begin
            mem[index] <= din;
        end
    end

    assign dout = mem[index];

endmodule

// File: rtl/dport_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// 16-byte lines (8 words); hits respond in the same cycle, misses stall via mem_resp.
// Ports: clk, reset (async active-high); MEM side mem_read/mem_write/
// mem_byte_enable/mem_address/mem_wdata -> mem_resp/mem_rdata; physical side
// pmem_read/pmem_write/pmem_address/pmem_wdata <- pmem_resp/pmem_rdata.
// Optional build macro DPORT_CACHE_PERF_EN adds perf_reset and the
// hit_count/miss_count/writeback_count saturating counters.
module dport_cache
    import dport_cache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
`ifdef DPORT_CACHE_PERF_EN
    ,
    input  logic         perf_reset,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count,
    output logic [15:0]  writeback_count
`endif
);

    localparam int unsigned S  = $clog2(NUM_SETS);
    localparam int unsigned TW = 12 - S;

    dport_cache_state_t state;

    logic [S-1:0]  idx;
    logic [TW-1:0] req_tag;
    lc3b_c_offset  off;
    logic          unused_addr_bit;

    assign idx             = mem_address[3+S:4];
    assign req_tag         = mem_address[15:4+S];
    assign off             = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];

    lc3b_line      line_out, line_in;
    logic [TW-1:0] tag_out;
    logic          valid_out, dirty_out;
    logic          data_load, tag_load, dirty_load, dirty_in;

    logic req, hit, in_check, miss_start, wr_hit, fill, wb_done;

    // Write has priority when both strobes are asserted; either is a request.
    assign req        = mem_read | mem_write;
    assign hit        = valid_out && (tag_out == req_tag);
    assign in_check   = (state == CHECK);
    assign mem_resp   = in_check && req && hit;
    assign mem_rdata  = line_word(line_out, off);
    assign miss_start = in_check && req && !hit;
    assign wr_hit     = mem_resp && mem_write && (mem_byte_enable != 2'b00);
    assign fill       = (state == ALLOCATE) && pmem_resp;
    assign wb_done    = (state == WRITEBACK) && pmem_resp;
    assign pmem_wdata = line_out;

    // Array write controls: a fill replaces the line, a write hit merges one word.
    always_comb begin
        data_load  = wr_hit | fill;
        tag_load   = fill;
        dirty_load = wr_hit | fill | wb_done;
        dirty_in   = wr_hit;
        line_in    = merge_word(line_out, off, mem_wdata, mem_byte_enable);
        if (fill) line_in = pmem_rdata;
    end

    dport_cache_array #(.WIDTH(LINE_W), .NUM_SETS(NUM_SETS)) u_data (
        .clk(clk), .rst(1'b0), .load(data_load), .index(idx), .din(line_in), .dout(line_out)
    );
    dport_cache_array #(.WIDTH(TW), .NUM_SETS(NUM_SETS)) u_tag (
        .clk(clk), .rst(1'b0), .load(tag_load), .index(idx), .din(req_tag), .dout(tag_out)
    );
    dport_cache_array #(.WIDTH(1), .NUM_SETS(NUM_SETS)) u_valid (
        .clk(clk), .rst(reset), .load(fill), .index(idx), .din(1'b1), .dout(valid_out)
    );
    dport_cache_array #(.WIDTH(1), .NUM_SETS(NUM_SETS)) u_dirty (
        .clk(clk), .rst(reset), .load(dirty_load), .index(idx), .din(dirty_in), .dout(dirty_out)
    );

    // Miss-handling FSM; physical-port strobes and line address are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= CHECK;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
        end else begin
            case (state)
                CHECK: begin
                    if (miss_start) begin
                        if (valid_out && dirty_out) begin
                            state        <= WRITEBACK;
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag_out, idx, 4'b0000};
                        end else begin
                            state        <= ALLOCATE;
                            pmem_read    <= 1'b1;
                            pmem_address <= {req_tag, idx, 4'b0000};
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state        <= ALLOCATE;
                        pmem_write   <= 1'b0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, idx, 4'b0000};
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        state     <= CHECK;
                        pmem_read <= 1'b0;
                    end
                end
                default: begin
                    state      <= CHECK;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef DPORT_CACHE_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count       <= '0;
            miss_count      <= '0;
            writeback_count <= '0;
        end else if (perf_reset) begin
            hit_count       <= '0;
            miss_count      <= '0;
            writeback_count <= '0;
        end else begin
            if (mem_resp && (hit_count != 16'hFFFF))       hit_count       <= hit_count + 16'd1;
            if (miss_start && (miss_count != 16'hFFFF))    miss_count      <= miss_count + 16'd1;
            if (wb_done && (writeback_count != 16'hFFFF))  writeback_count <= writeback_count + 16'd1;
        end
    end
`endif

endmodule
